// File: rtl/lp805x_sfr_timer.sv
// 16-bit SFR-mapped timer with optional divide-by-12 prescale, auto-reload and
// an overflow interrupt, attached to the lp805x SFR request/response buses.
module lp805x_sfr_timer #(
  parameter logic [7:0] CON_ADDR = 8'hC8,
  parameter logic [7:0] RL_ADDR  = 8'hCA,
  parameter logic [7:0] RH_ADDR  = 8'hCB,
  parameter logic [7:0] TL_ADDR  = 8'hCC,
  parameter logic [7:0] TH_ADDR  = 8'hCD
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [28:0] sfr_bus_i,
  input  logic        irq_ack,
  output logic [9:0]  sfr_bus_o,
  output logic        irq
);

  // Writable CON fields: TF, IE, PSE, ARL, TR.
  localparam logic [7:0] CON_MASK = 8'hC7;

  logic [7:0]  wr_addr_s, rd_addr_s, data_in_s;
  logic        wr_s, rd_s, bit_in_s, wr_bit_s, rd_bit_s;
  logic        wr_con_s, wr_rl_s, wr_rh_s, wr_tl_s, wr_th_s;
  logic        bit_wr_s, bit_rd_s, cnt_wr_s, pse_chg_s, tick_s, ovf_s;
  logic [7:0]  con_sw_s, con_nxt_s, rd_mux_s;
  logic [15:0] cnt_s, cnt_nxt_s;
  logic [3:0]  presc_nxt_s;

  logic [7:0]  con_r, rl_r, rh_r, tl_r, th_r, rd_data_r;
  logic [3:0]  presc_r;
  logic        bit_out_r, irq_r;

  assign wr_addr_s = sfr_bus_i[28:21];
  assign rd_addr_s = sfr_bus_i[20:13];
  assign data_in_s = sfr_bus_i[12:5];
  assign wr_s      = sfr_bus_i[4];
  assign rd_s      = sfr_bus_i[3];
  assign bit_in_s  = sfr_bus_i[2];
  assign wr_bit_s  = sfr_bus_i[1];
  assign rd_bit_s  = sfr_bus_i[0];

  assign wr_con_s  = wr_s && (wr_addr_s == CON_ADDR);
  assign wr_rl_s   = wr_s && (wr_addr_s == RL_ADDR);
  assign wr_rh_s   = wr_s && (wr_addr_s == RH_ADDR);
  assign wr_tl_s   = wr_s && (wr_addr_s == TL_ADDR);
  assign wr_th_s   = wr_s && (wr_addr_s == TH_ADDR);
  assign cnt_wr_s  = wr_tl_s || wr_th_s;
  assign bit_wr_s  = wr_bit_s && (wr_addr_s[7:3] == CON_ADDR[7:3]);
  assign bit_rd_s  = rd_bit_s && (rd_addr_s[7:3] == CON_ADDR[7:3]);
  assign cnt_s     = {th_r, tl_r};

  // Software view of CON after this cycle's byte/bit write; byte write wins.
  always_comb begin
    con_sw_s = con_r;
    if (wr_con_s) begin
      con_sw_s = data_in_s & CON_MASK;
    end else if (bit_wr_s) begin
      con_sw_s[wr_addr_s[2:0]] = bit_in_s & CON_MASK[wr_addr_s[2:0]];
    end else begin
      con_sw_s = con_r;
    end
  end

  assign pse_chg_s = (con_sw_s[2] != con_r[2]);

  // Tick and prescaler: every cycle when PSE=0, once per 12 cycles when PSE=1.
  always_comb begin
    tick_s      = 1'b0;
    presc_nxt_s = presc_r;
    if (con_r[0]) begin
      tick_s = !con_r[2] || (presc_r == 4'd11);
    end else begin
      tick_s = 1'b0;
    end
    if (pse_chg_s) begin
      presc_nxt_s = 4'd0;
    end else if (con_r[0] && con_r[2]) begin
      presc_nxt_s = (presc_r == 4'd11) ? 4'd0 : presc_r + 4'd1;
    end else begin
      presc_nxt_s = presc_r;
    end
  end

  // A byte write to TL/TH pre-empts the count, so it can never overflow then.
  assign ovf_s = tick_s && !cnt_wr_s && (cnt_s == 16'hFFFF);

  // Next count value: software write, overflow reload, increment or hold.
  always_comb begin
    cnt_nxt_s = cnt_s;
    if (cnt_wr_s) begin
      cnt_nxt_s[7:0]  = wr_tl_s ? data_in_s : tl_r;
      cnt_nxt_s[15:8] = wr_th_s ? data_in_s : th_r;
    end else if (ovf_s) begin
      cnt_nxt_s = con_r[1] ? {rh_r, rl_r} : 16'h0000;
    end else if (tick_s) begin
      cnt_nxt_s = cnt_s + 16'd1;
    end else begin
      cnt_nxt_s = cnt_s;
    end
  end

  // Hardware overflow beats both the acknowledge and a software clear of TF.
  assign con_nxt_s = {ovf_s || (con_sw_s[7] && !irq_ack), con_sw_s[6:0]};

  // Byte read mux; unmapped addresses read as zero.
  always_comb begin
    rd_mux_s = 8'h00;
    case (rd_addr_s)
      CON_ADDR: rd_mux_s = con_r;
      RL_ADDR:  rd_mux_s = rl_r;
      RH_ADDR:  rd_mux_s = rh_r;
      TL_ADDR:  rd_mux_s = tl_r;
      TH_ADDR:  rd_mux_s = th_r;
      default:  rd_mux_s = 8'h00;
    endcase
  end

  // Timer state, read-data pipeline and interrupt register.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      con_r     <= 8'h00;
      rl_r      <= 8'h00;
      rh_r      <= 8'h00;
      tl_r      <= 8'h00;
      th_r      <= 8'h00;
      presc_r   <= 4'd0;
      rd_data_r <= 8'h00;
      bit_out_r <= 1'b0;
      irq_r     <= 1'b0;
    end else begin
      con_r     <= con_nxt_s;
      rl_r      <= wr_rl_s ? data_in_s : rl_r;
      rh_r      <= wr_rh_s ? data_in_s : rh_r;
      tl_r      <= cnt_nxt_s[7:0];
      th_r      <= cnt_nxt_s[15:8];
      presc_r   <= presc_nxt_s;
      rd_data_r <= rd_s ? rd_mux_s : 8'h00;
      bit_out_r <= bit_rd_s ? con_r[rd_addr_s[2:0]] : 1'b0;
      irq_r     <= con_r[7] && con_r[6];
    end
  end

  assign sfr_bus_o = {rd_data_r, bit_out_r, 1'b0};
  assign irq       = irq_r;

endmodule

// File: tb/tb_lp805x_sfr_timer.sv
// Directed self-checking bench for lp805x_sfr_timer; inputs change and outputs
// are sampled on the falling edge, one rising edge per bus operation.
module tb_lp805x_sfr_timer;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        irq_ack = 1'b0;
  logic [28:0] sfr_bus_i;
  logic [9:0]  sfr_bus_o;
  logic        irq;

  logic [7:0] wr_addr = 8'h00, rd_addr = 8'h00, data_in = 8'h00;
  logic       wr = 1'b0, rd = 1'b0, bit_in = 1'b0, wr_bit = 1'b0, rd_bit = 1'b0;

  int n_checks = 0;
  int n_fails  = 0;

  assign sfr_bus_i = {wr_addr, rd_addr, data_in, wr, rd, bit_in, wr_bit, rd_bit};

  lp805x_sfr_timer dut (
    .clk       (clk),
    .rst       (rst),
    .sfr_bus_i (sfr_bus_i),
    .irq_ack   (irq_ack),
    .sfr_bus_o (sfr_bus_o),
    .irq       (irq)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fails++;
      $display("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic wr_byte(input logic [7:0] a, input logic [7:0] d);
    wr_addr = a; data_in = d; wr = 1'b1;
    step();
    wr = 1'b0; data_in = 8'h00;
  endtask

  task automatic wr_bitop(input logic [7:0] a, input logic b);
    wr_addr = a; bit_in = b; wr_bit = 1'b1;
    step();
    wr_bit = 1'b0; bit_in = 1'b0;
  endtask

  task automatic rd_byte(input logic [7:0] a, output logic [7:0] d);
    rd_addr = a; rd = 1'b1;
    step();
    rd = 1'b0;
    d = sfr_bus_o[9:2];
  endtask

  task automatic rd_bitop(input logic [7:0] a, output logic b);
    rd_addr = a; rd_bit = 1'b1;
    step();
    rd_bit = 1'b0;
    b = sfr_bus_o[1];
  endtask

  initial begin
    logic [7:0] d;
    logic       b;
    logic [7:0] regs [5];
    regs[0] = 8'hC8; regs[1] = 8'hCA; regs[2] = 8'hCB; regs[3] = 8'hCC; regs[4] = 8'hCD;

    // Reset state
    repeat (2) @(negedge clk);
    check("irq_in_reset", 16'(irq), 16'h0000);
    rst = 1'b1;
    @(negedge clk);
    for (int i = 0; i < 5; i++) begin
      rd_byte(regs[i], d);
      check("reset_reg", 16'(d), 16'h0000);
    end
    check("reset_irq", 16'(irq), 16'h0000);
    check("unused_bit0", 16'(sfr_bus_o[0]), 16'h0000);

    // Overflow to zero, interrupt and acknowledge
    wr_byte(8'hCC, 8'hFE);
    wr_byte(8'h80, 8'h5A);
    rd_byte(8'h80, d);
    check("unmapped_read", 16'(d), 16'h0000);
    wr_byte(8'hCD, 8'hFF);
    wr_byte(8'hC8, 8'h41);
    rd_bitop(8'hCF, b);
    check("tf_before_1", 16'(b), 16'h0000);
    rd_bitop(8'hCF, b);
    check("tf_before_2", 16'(b), 16'h0000);
    check("irq_before", 16'(irq), 16'h0000);
    rd_byte(8'hCC, d);
    check("ovf_tl_zero", 16'(d), 16'h0000);
    check("irq_after_tf", 16'(irq), 16'h0001);
    rd_bitop(8'hCF, b);
    check("tf_set", 16'(b), 16'h0001);
    rd_byte(8'hCD, d);
    check("ovf_th_zero", 16'(d), 16'h0000);
    irq_ack = 1'b1;
    step();
    irq_ack = 1'b0;
    check("irq_lag_ack", 16'(irq), 16'h0001);
    rd_bitop(8'hCF, b);
    check("tf_acked", 16'(b), 16'h0000);
    check("irq_cleared", 16'(irq), 16'h0000);

    // Auto-reload
    wr_byte(8'hC8, 8'h00);
    wr_byte(8'hCA, 8'h34);
    wr_byte(8'hCB, 8'h12);
    wr_byte(8'hCC, 8'hFF);
    wr_byte(8'hCD, 8'hFF);
    wr_byte(8'hC8, 8'h03);
    rd_byte(8'hCC, d);
    check("arl_pre_tl", 16'(d), 16'h00FF);
    rd_byte(8'hCC, d);
    check("arl_tl", 16'(d), 16'h0034);
    rd_byte(8'hCD, d);
    check("arl_th", 16'(d), 16'h0012);
    rd_bitop(8'hCF, b);
    check("arl_tf", 16'(b), 16'h0001);

    // Prescale by 12; continuous read shows TL as of the previous edge
    wr_byte(8'hC8, 8'h00);
    wr_byte(8'hCC, 8'h00);
    wr_byte(8'hCD, 8'h00);
    wr_byte(8'hC8, 8'h05);
    rd_addr = 8'hCC; rd = 1'b1;
    for (int k = 1; k <= 25; k++) begin
      step();
      if (k == 12) check("pse_tl_11", 16'(sfr_bus_o[9:2]), 16'h0000);
      if (k == 13) check("pse_tl_12", 16'(sfr_bus_o[9:2]), 16'h0001);
      if (k == 24) check("pse_tl_23", 16'(sfr_bus_o[9:2]), 16'h0001);
      if (k == 25) check("pse_tl_24", 16'(sfr_bus_o[9:2]), 16'h0002);
    end
    rd = 1'b0;

    // Bit access and overflow-beats-clear
    wr_byte(8'hC8, 8'h00);
    wr_bitop(8'hC8, 1'b1);
    rd_bitop(8'hC8, b);
    check("bit_tr", 16'(b), 16'h0001);
    wr_bitop(8'hC9, 1'b1);
    rd_bitop(8'hC9, b);
    check("bit_arl", 16'(b), 16'h0001);
    wr_bitop(8'hCB, 1'b1);
    rd_byte(8'hC8, d);
    check("con_after_bits", 16'(d), 16'h0003);
    wr_byte(8'hC8, 8'h00);
    wr_byte(8'hCC, 8'hFE);
    wr_byte(8'hCD, 8'hFF);
    wr_byte(8'hC8, 8'h81);
    step();
    wr_bitop(8'hCF, 1'b0);
    rd_bitop(8'hCF, b);
    check("tf_ovf_priority", 16'(b), 16'h0001);
    wr_bitop(8'hCF, 1'b0);
    rd_bitop(8'hCF, b);
    check("tf_sw_clear", 16'(b), 16'h0000);

    // Write TL in a tick cycle that would otherwise carry into TH
    wr_byte(8'hC8, 8'h00);
    wr_byte(8'hCC, 8'hFE);
    wr_byte(8'hCD, 8'h20);
    wr_byte(8'hC8, 8'h01);
    step();
    wr_byte(8'hCC, 8'hAA);
    rd_byte(8'hCC, d);
    check("wr_tl_value", 16'(d), 16'h00AA);
    rd_byte(8'hCD, d);
    check("wr_th_hold", 16'(d), 16'h0020);

    // Asynchronous reset mid-count with prescale enabled
    wr_byte(8'hC8, 8'hC5);
    rd_addr = 8'hCD; rd = 1'b1;
    step();
    step();
    check("pre_rst_th", 16'(sfr_bus_o[9:2]), 16'h0020);
    check("pre_rst_irq", 16'(irq), 16'h0001);
    #2 rst = 1'b0;
    #1;
    check("async_rst_data", 16'(sfr_bus_o[9:2]), 16'h0000);
    check("async_rst_irq", 16'(irq), 16'h0000);
    rd = 1'b0;
    @(negedge clk);
    rst = 1'b1;
    for (int i = 0; i < 5; i++) begin
      rd_byte(regs[i], d);
      check("post_rst_reg", 16'(d), 16'h0000);
    end
    repeat (3) step();
    rd_byte(8'hCC, d);
    check("no_count_after_rst", 16'(d), 16'h0000);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
    $finish;
  end

endmodule
